pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..6.
REQ-003 SHALL have parameter BR_STAGE, default 2, the stage index at which a taken branch is resolved; legal range 1..DEPTH.
REQ-004 SHALL have parameter FWD_EN, default 1; 0 disables forwarding, so every RAW hazard stalls.
REQ-005 SHALL have the following ports (one clock; reset is asynchronous and active-low):
  Clk  in  1  rising-edge clock.
  Reset  in  1  asynchronous, active-low reset.
  id_valid  in  1  ID holds a real instruction.
  id_rs, id_rt  in  REG_AW  source registers of the ID instruction.
  id_use_rs, id_use_rt  in  1  the corresponding source is actually read.
  id_dest  in  REG_AW  destination register of the ID instruction.
  id_reg_write  in  1  the ID instruction writes id_dest.
  id_mem_read  in  1  the ID instruction is a load.
  branch_taken  in  1  the branch at stage BR_STAGE is taken.
  stall  out  1  hold PC and IF/ID; inject a bubble into EX.
  flush  out  1  clear IF/ID and every stage younger than BR_STAGE.
  fwd_a_sel, fwd_b_sel  out  clog2(DEPTH+1)  0 = register file; k = forward from stage k.
  stall_cnt, flush_cnt  out  16  saturating event counters.

Function
REQ-006 SHALL keep a scoreboard of DEPTH entries {valid, dest, reg_write, mem_read}, where entry k mirrors pipeline stage k.
REQ-007 Each cycle, entry k SHALL shift into entry k+1 and entry DEPTH SHALL be discarded.
REQ-008 Entry 1 SHALL load the ID fields, qualified by id_valid, when neither stall nor flush is asserted.
REQ-009 Entry 1 SHALL load a bubble (valid=0) when stall or flush is asserted.
REQ-010 A source SHALL match entry k only when: valid, reg_write, dest==source, source!=0, and use_* is set.
REQ-011 With FWD_EN=1, stall SHALL assert combinationally when id_valid is set and any used source matches entry 1 with mem_read=1 (load-use).
REQ-012 With FWD_EN=0, stall SHALL assert when any used source matches any entry 1..DEPTH-1; the WB-stage match is excluded because the register file is write-then-read.
REQ-013 With FWD_EN=1 and no stall, fwd_*_sel SHALL equal the smallest k in 1..DEPTH-1 that matches (youngest wins), else 0.
REQ-014 fwd_*_sel SHALL be 0 whenever FWD_EN=0, stall=1, or id_valid=0.
REQ-015 flush SHALL equal branch_taken.
REQ-016 On flush, entries 1..BR_STAGE-1 SHALL be invalidated on the same edge as the shift.
REQ-017 branch_taken SHALL override stall: stall is forced to 0 in a flush cycle.
REQ-018 A stall SHALL last exactly one cycle per load-use pair; after the bubble, the load sits in entry 2 and its result is forwarded.
REQ-019 stall_cnt SHALL increment on each clock edge where stall=1, and flush_cnt on each edge where flush=1.
REQ-020 Both counters SHALL saturate at 16'hFFFF.
REQ-021 stall, flush and fwd_* SHALL have zero-cycle latency from their inputs; only the scoreboard and counters are registered.

Reset
REQ-022 Reset low SHALL immediately clear all scoreboard entries (valid=0) and zero stall_cnt and flush_cnt.
REQ-023 While Reset is low, stall=0, flush=branch_taken, and fwd_*_sel=0.
REQ-024 Reset asserted mid-stall or mid-flush SHALL abandon the event; no counter increment occurs on that edge.

Structure
REQ-025 A shared package SHALL hold the scoreboard-entry struct and the fwd_sel width function clog2(DEPTH+1).
REQ-026 A shared package SHALL hold the named stage constants STG_EX=1, STG_MEM=2, STG_WB=3.
REQ-027 Per-source match/priority logic SHALL be one sub-module, hazard_src_match, instantiated twice (rs and rt).

Verification
REQ-028 Load-use: lw $8 followed by add $9,$8,$10 (FWD_EN=1) -> stall=1 for exactly 1 cycle, then fwd_a_sel=2, stall_cnt=1.
REQ-029 ALU chain: add $8 followed by sub $9,$8,$8 -> stall=0, fwd_a_sel=1, fwd_b_sel=1; with one instruction between them, both sel=2.
REQ-030 Register 0: writes to $0 followed by reads of $0 -> stall=0, both sel=0.
REQ-031 Simultaneous events: branch_taken=1 in the same cycle as a load-use hazard -> flush=1, stall=0, entries 1..BR_STAGE-1 invalid next cycle, flush_cnt=1, stall_cnt unchanged.
REQ-032 No forwarding: FWD_EN=0, DEPTH=3, add $8 then read $8 -> stall for 2 cycles, then proceed with sel=0; stall_cnt=2.
REQ-033 Reset and saturation: Reset pulsed low mid-stall -> outputs clear asynchronously; after 65536+ forced stalls, stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
//==============================================================
// pipe_hazard_ctrl_pkg : shared types and constants for the hazard unit
// Rev 1.0
//==============================================================
`timescale 1ns/1ps
`default_nettype none

package pipe_hazard_ctrl_pkg;

   localparam int STG_EX  = 1;
   localparam int STG_MEM = 2;
   localparam int STG_WB  = 3;

   // Entries hold register numbers zero-extended to this width; REG_AW must not exceed it.
   localparam int MAX_REG_AW = 16;

   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] dest;
      logic                  reg_write;
      logic                  mem_read;
   } sb_entry_t;

   function automatic int fsel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
//==============================================================
// pipe_hazard_ctrl_if : ID-stage request and hazard-response bundle
// Rev 1.0
//==============================================================
`timescale 1ns/1ps
`default_nettype none

interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3
) ();
   import pipe_hazard_ctrl_pkg::*;

   localparam int FSEL_W = fsel_w(DEPTH);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_dest;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              branch_taken;
   logic              stall;
   logic              flush;
   logic [FSEL_W-1:0] fwd_a_sel;
   logic [FSEL_W-1:0] fwd_b_sel;
   logic [15:0]       stall_cnt;
   logic [15:0]       flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
             id_reg_write, id_mem_read, branch_taken,
      input  stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
             id_reg_write, id_mem_read, branch_taken,
      output stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_src_match.sv
//==============================================================
// hazard_src_match : per-source scoreboard match, stall need and forward select
// Rev 1.0
//==============================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_src_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int FSEL_W = 2
) (
   input  sb_entry_t [DEPTH:1]    sb,
   input  logic [MAX_REG_AW-1:0]  src,
   input  logic                   use_src,
   output logic                   need_stall,
   output logic [FSEL_W-1:0]      sel
);

   logic [DEPTH-1:1] hit;
   logic             unused_sb;

   always_comb begin
      hit        = '0;
      sel        = '0;
      need_stall = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
         hit[k] = sb[k].valid & sb[k].reg_write & use_src &
                  (src != '0) & (sb[k].dest == src);
      end
      // Walk oldest to youngest so the youngest producer ends up selected.
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (hit[k]) sel = FSEL_W'(k);
      end
      if (FWD_EN != 0) need_stall = hit[1] & sb[1].mem_read;
      else             need_stall = |hit;
   end

   // The WB entry and older load flags never affect a decision.
   always_comb begin
      unused_sb = ^sb[DEPTH];
      for (int k = 2; k < DEPTH; k++) unused_sb = unused_sb ^ sb[k].mem_read;
   end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//==============================================================
// pipe_hazard_ctrl : in-order pipeline RAW stall / forward / flush control
// Rev 1.0
//==============================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 3,
   parameter int BR_STAGE = 2,
   parameter int FWD_EN   = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int FSEL_W = fsel_w(DEPTH);

   sb_entry_t [DEPTH:1] sb;
   sb_entry_t           entry_in;
   logic                stall_rs, stall_rt;
   logic [FSEL_W-1:0]   sel_rs, sel_rt;
   logic                stall_w, fwd_ok;
   logic [15:0]         stall_cnt_q, flush_cnt_q;

   hazard_src_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .FSEL_W(FSEL_W)) u_rs (
      .sb         (sb),
      .src        (MAX_REG_AW'(bus.id_rs)),
      .use_src    (bus.id_use_rs),
      .need_stall (stall_rs),
      .sel        (sel_rs)
   );

   hazard_src_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .FSEL_W(FSEL_W)) u_rt (
      .sb         (sb),
      .src        (MAX_REG_AW'(bus.id_rt)),
      .use_src    (bus.id_use_rt),
      .need_stall (stall_rt),
      .sel        (sel_rt)
   );

   // A taken branch wins over a stall; reset level masks everything but flush.
   assign stall_w = Reset & ~bus.branch_taken & bus.id_valid & (stall_rs | stall_rt);
   assign fwd_ok  = (FWD_EN != 0) & Reset & bus.id_valid & ~stall_w;

   assign bus.stall     = stall_w;
   assign bus.flush     = bus.branch_taken;
   assign bus.fwd_a_sel = fwd_ok ? sel_rs : '0;
   assign bus.fwd_b_sel = fwd_ok ? sel_rt : '0;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

   always_comb begin
      entry_in = '0;
      if (!stall_w && !bus.branch_taken) begin
         entry_in.valid     = bus.id_valid;
         entry_in.dest      = MAX_REG_AW'(bus.id_dest);
         entry_in.reg_write = bus.id_reg_write;
         entry_in.mem_read  = bus.id_mem_read;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sb          <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         sb[1] <= entry_in;
         // Instructions younger than the resolving branch are squashed as they shift.
         for (int k = 2; k <= DEPTH; k++) begin
            sb[k] <= (bus.branch_taken && k <= BR_STAGE) ? sb_entry_t'('0) : sb[k-1];
         end
         if (stall_w && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (bus.branch_taken && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================
// tb_pipe_hazard_ctrl : directed scoreboard bench for pipe_hazard_ctrl
// Rev 1.0
//==============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rst_s = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3)) bus_a ();
   pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3)) bus_b ();
   pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(6)) bus_s ();

   pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .BR_STAGE(2), .FWD_EN(1)) dut_a (
      .Clk(clk), .Reset(rst_n), .bus(bus_a));
   pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .BR_STAGE(2), .FWD_EN(0)) dut_b (
      .Clk(clk), .Reset(rst_n), .bus(bus_b));
   pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(6), .BR_STAGE(2), .FWD_EN(0)) dut_s (
      .Clk(clk), .Reset(rst_s), .bus(bus_s));

   typedef struct {
      string      tag;
      int         dut;
      logic       stall;
      logic       flush;
      logic [2:0] fa;
      logic [2:0] fb;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic idle_all();
      bus_a.id_valid = 0; bus_a.id_rs = 0; bus_a.id_rt = 0; bus_a.id_use_rs = 0;
      bus_a.id_use_rt = 0; bus_a.id_dest = 0; bus_a.id_reg_write = 0;
      bus_a.id_mem_read = 0; bus_a.branch_taken = 0;
      bus_b.id_valid = 0; bus_b.id_rs = 0; bus_b.id_rt = 0; bus_b.id_use_rs = 0;
      bus_b.id_use_rt = 0; bus_b.id_dest = 0; bus_b.id_reg_write = 0;
      bus_b.id_mem_read = 0; bus_b.branch_taken = 0;
   endtask

   // Drive one ID cycle on dut d (0=forwarding unit, 1=no-forwarding unit),
   // queue its expected response and compare it mid-cycle.
   task automatic step(input string tag, input int d, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic bt,
                       input logic es, input logic ef, input int efa, input int efb);
      exp_t e;
      logic       o_stall, o_flush;
      logic [2:0] o_fa, o_fb;
      @(negedge clk);
      idle_all();
      if (d == 0) begin
         bus_a.id_valid = v; bus_a.id_rs = rs; bus_a.id_rt = rt; bus_a.id_use_rs = urs;
         bus_a.id_use_rt = urt; bus_a.id_dest = dst; bus_a.id_reg_write = rw;
         bus_a.id_mem_read = mr; bus_a.branch_taken = bt;
      end else begin
         bus_b.id_valid = v; bus_b.id_rs = rs; bus_b.id_rt = rt; bus_b.id_use_rs = urs;
         bus_b.id_use_rt = urt; bus_b.id_dest = dst; bus_b.id_reg_write = rw;
         bus_b.id_mem_read = mr; bus_b.branch_taken = bt;
      end
      q.push_back('{tag, d, es, ef, 3'(efa), 3'(efb)});
      #2;
      e = q.pop_front();
      if (e.dut == 0) begin
         o_stall = bus_a.stall; o_flush = bus_a.flush;
         o_fa = 3'(bus_a.fwd_a_sel); o_fb = 3'(bus_a.fwd_b_sel);
      end else begin
         o_stall = bus_b.stall; o_flush = bus_b.flush;
         o_fa = 3'(bus_b.fwd_a_sel); o_fb = 3'(bus_b.fwd_b_sel);
      end
      check({e.tag, "_stall"}, 16'(o_stall), 16'(e.stall));
      check({e.tag, "_flush"}, 16'(o_flush), 16'(e.flush));
      check({e.tag, "_fwd_a"}, 16'(o_fa), 16'(e.fa));
      check({e.tag, "_fwd_b"}, 16'(o_fb), 16'(e.fb));
   endtask

   initial begin
      idle_all();
      // Saturation unit: an ever-repeating RAW on $8 without forwarding.
      bus_s.id_valid = 1; bus_s.id_rs = 5'd8; bus_s.id_rt = 0; bus_s.id_use_rs = 1;
      bus_s.id_use_rt = 0; bus_s.id_dest = 5'd8; bus_s.id_reg_write = 1;
      bus_s.id_mem_read = 0; bus_s.branch_taken = 0;

      // While in reset: stall masked, flush follows branch_taken, no counting.
      step("in_reset", 0, 1, 8, 8, 1, 1, 8, 1, 1, 1, 0, 1, 0, 0);
      @(negedge clk);
      idle_all();
      rst_n = 1'b1;
      rst_s = 1'b1;
      check("rst_stall_cnt", bus_a.stall_cnt, 16'h0000);
      check("rst_flush_cnt", bus_a.flush_cnt, 16'h0000);

      // Load-use: lw $8 ; add $9,$8,$10
      step("lw8",        0, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0);
      step("ld_use",     0, 1, 8, 10, 1, 1, 9, 1, 0, 0, 1, 0, 0, 0);
      @(posedge clk); #1;
      check("ld_use_cnt", bus_a.stall_cnt, 16'd1);
      step("ld_fwd_mem", 0, 1, 8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 2, 0);
      // ALU chains at distance 1 and 2, then a WB-only producer.
      step("alu_ex",     0, 1, 9, 9, 1, 1, 11, 1, 0, 0, 0, 0, 1, 1);
      step("filler",     0, 1, 1, 2, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
      step("alu_mem",    0, 1, 11, 11, 1, 1, 13, 1, 0, 0, 0, 0, 2, 2);
      step("wb_vs_ex",   0, 1, 11, 13, 1, 1, 14, 1, 0, 0, 0, 0, 0, 1);
      // Register 0 never hazards, even as a load target.
      step("lw_r0",      0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      step("rd_r0",      0, 1, 0, 0, 1, 1, 15, 1, 0, 0, 0, 0, 0, 0);
      step("id_invalid", 0, 0, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("lw16",       0, 1, 1, 0, 1, 0, 16, 1, 1, 0, 0, 0, 0, 0);
      step("no_use",     0, 1, 16, 16, 0, 0, 17, 0, 0, 0, 0, 0, 0, 0);
      // Branch taken alongside a load-use hazard.
      step("lw8_b",      0, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0);
      step("br_ld_use",  0, 1, 8, 10, 1, 1, 9, 1, 0, 1, 0, 1, 1, 0);
      @(posedge clk); #1;
      check("br_flush_cnt", bus_a.flush_cnt, 16'd1);
      check("br_stall_cnt", bus_a.stall_cnt, 16'd1);
      step("after_flush", 0, 1, 9, 0, 1, 1, 18, 1, 0, 0, 0, 0, 0, 0);

      // Reset pulsed mid-stall.
      step("lw20",       0, 1, 1, 0, 1, 0, 20, 1, 1, 0, 0, 0, 0, 0);
      step("pre_rst",    0, 1, 20, 0, 1, 0, 21, 1, 0, 0, 1, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_stall", 16'(bus_a.stall), 16'd0);
      check("async_scnt",  bus_a.stall_cnt, 16'd0);
      check("async_fcnt",  bus_a.flush_cnt, 16'd0);
      @(posedge clk); #1;
      check("rst_edge_scnt", bus_a.stall_cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst",   0, 1, 20, 0, 1, 0, 21, 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("post_rst_scnt", bus_a.stall_cnt, 16'd0);

      // No forwarding: add $8 then read $8 stalls through EX and MEM.
      step("nf_add8",    1, 1, 1, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0);
      step("nf_ex",      1, 1, 8, 0, 1, 0, 9, 1, 0, 0, 1, 0, 0, 0);
      step("nf_mem",     1, 1, 8, 0, 1, 0, 9, 1, 0, 0, 1, 0, 0, 0);
      step("nf_wb",      1, 1, 8, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("nf_scnt", bus_b.stall_cnt, 16'd2);

      // Saturation unit stalls 5 of every 6 cycles; well past 65535 by now.
      repeat (79000) @(posedge clk);
      #1;
      check("sat_scnt", bus_s.stall_cnt, 16'hFFFF);
      repeat (7) @(posedge clk);
      #1;
      check("sat_hold", bus_s.stall_cnt, 16'hFFFF);
      check("sat_fcnt", bus_s.flush_cnt, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
